// File: rtl/uart9_addr_rx.sv
// 9-bit multiprocessor UART receiver with address filtering.
// Data frames that follow a matching address frame are queued in a FWFT FIFO.
module uart9_addr_rx #(
    parameter int                DATA_W       = 8,
    parameter int                CLKS_PER_BIT = 16,
    parameter int                FIFO_DEPTH   = 8,
    parameter logic [DATA_W-1:0] BCAST_ADDR   = {DATA_W{1'b1}}
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_i,
    input  logic [DATA_W-1:0]             my_addr,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          addressed,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TICK_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_W) + 1;

    // The half-bit wait is two short because IDLE spends one cycle noticing the edge.
    localparam logic [TICK_W-1:0] FULL_TICK = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(CLKS_PER_BIT / 2 - 2);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_FLAG,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    logic              r_sync1;
    logic              r_sync2;
    logic              w_rxS;

    state_t            r_state;
    logic [TICK_W-1:0] r_tick;
    logic [BIT_W-1:0]  r_bitCnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_flag;
    logic              r_commit;
    logic              r_stopErr;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;

    logic              w_pop;
    logic              w_dataFrame;
    logic              w_push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxS = r_sync2;

    // Frame sequencer; r_commit and r_stopErr are single-cycle strobes to the commit stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_tick    <= '0;
            r_bitCnt  <= '0;
            r_shift   <= '0;
            r_flag    <= 1'b0;
            r_commit  <= 1'b0;
            r_stopErr <= 1'b0;
        end else begin
            r_commit  <= 1'b0;
            r_stopErr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_rxS) begin
                        r_state  <= S_START;
                        r_tick   <= '0;
                        r_bitCnt <= '0;
                    end
                end
                S_START: begin
                    if (r_tick == HALF_TICK) begin
                        r_tick  <= '0;
                        r_state <= w_rxS ? S_IDLE : S_DATA;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_tick == FULL_TICK) begin
                        r_tick  <= '0;
                        r_shift <= {w_rxS, r_shift[DATA_W-1:1]};
                        if (r_bitCnt == LAST_BIT) begin
                            r_state <= S_FLAG;
                        end else begin
                            r_bitCnt <= r_bitCnt + 1'b1;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                S_FLAG: begin
                    if (r_tick == FULL_TICK) begin
                        r_tick  <= '0;
                        r_flag  <= w_rxS;
                        r_state <= S_STOP;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_tick == FULL_TICK) begin
                        r_tick <= '0;
                        if (w_rxS) begin
                            r_commit <= 1'b1;
                            r_state  <= S_IDLE;
                        end else begin
                            r_stopErr <= 1'b1;
                            r_state   <= S_WAIT_IDLE;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (w_rxS) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign empty       = (r_count == '0);
    assign full        = (r_count == CNT_FULL);
    assign count       = r_count;
    assign w_pop       = rd_en && !empty;
    assign w_dataFrame = r_commit && !r_flag && addressed;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign w_push      = w_dataFrame && (!full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addressed <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= r_stopErr;
            overflow  <= w_dataFrame && full && !w_pop;
            if (r_commit && r_flag) begin
                addressed <= (r_shift == my_addr) || (r_shift == BCAST_ADDR);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= r_shift;
        end
    end

    assign rd_data = empty ? '0 : r_mem[r_rdPtr];

endmodule

// File: tb/tb_uart9_addr_rx.sv
// Directed bench for uart9_addr_rx with default parameters.
// Frames are driven bit-serially; pulse outputs are tallied by a monitor.
module tb_uart9_addr_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_i;
    logic [7:0] my_addr;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [3:0] count;
    logic       addressed;
    logic       frame_err;
    logic       overflow;

    int vectorCount = 0;
    int missCount   = 0;
    int ferrSeen    = 0;
    int ovSeen      = 0;

    always #5 clk = ~clk;

    uart9_addr_rx #(
        .DATA_W       (8),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8),
        .BCAST_ADDR   (8'hFF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_i      (rx_i),
        .my_addr   (my_addr),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .addressed (addressed),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always @(posedge clk) begin
        if (frame_err) ferrSeen++;
        if (overflow)  ovSeen++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectorCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives start, 8 data bits LSB first, flag and stop; rx is left at the stop level.
    task automatic applyStimulus(input logic flag, input logic [7:0] data, input logic stopBit);
        logic [10:0] bits;
        bits = {stopBit, flag, data, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            rx_i = bits[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic popExpect(input string tag, input logic [31:0] exp);
        checkOutput(tag, {24'h0, rd_data}, exp);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        rx_i    = 1'b1;
        rd_en   = 1'b0;
        my_addr = 8'h06;
        repeat (3) @(negedge clk);
        checkOutput("rst_empty",     32'(empty),     32'h1);
        checkOutput("rst_full",      32'(full),      32'h0);
        checkOutput("rst_count",     32'(count),     32'h0);
        checkOutput("rst_addressed", 32'(addressed), 32'h0);
        checkOutput("rst_frame_err", 32'(frame_err), 32'h0);
        checkOutput("rst_overflow",  32'(overflow),  32'h0);
        checkOutput("rst_rd_data",   32'(rd_data),   32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Address match, with commit timing measured from t0.
        fork
            applyStimulus(1'b1, 8'h06, 1'b1);
            begin
                @(negedge clk);
                @(posedge clk);
                repeat (169) @(posedge clk);
                #1 checkOutput("addr_t169", 32'(addressed), 32'h0);
                @(posedge clk);
                #1 checkOutput("addr_t170", 32'(addressed), 32'h1);
            end
        join
        applyStimulus(1'b0, 8'hF0, 1'b1);
        checkOutput("match_rd_data", 32'(rd_data), 32'hF0);
        checkOutput("match_empty",   32'(empty),   32'h0);
        checkOutput("match_count",   32'(count),   32'h1);
        popExpect("match_pop", 32'hF0);
        checkOutput("match_pop_empty", 32'(empty), 32'h1);

        // Address mismatch deselects and data is ignored.
        applyStimulus(1'b1, 8'h05, 1'b1);
        checkOutput("miss_addressed", 32'(addressed), 32'h0);
        applyStimulus(1'b0, 8'h0E, 1'b1);
        checkOutput("miss_empty", 32'(empty), 32'h1);
        checkOutput("miss_ferr",  32'(ferrSeen), 32'h0);
        checkOutput("miss_ovf",   32'(ovSeen),   32'h0);

        // Broadcast.
        applyStimulus(1'b1, 8'hFF, 1'b1);
        checkOutput("bcast_addressed", 32'(addressed), 32'h1);
        applyStimulus(1'b0, 8'hA5, 1'b1);
        popExpect("bcast_pop", 32'hA5);

        // Overflow on the ninth frame.
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'(i), 1'b1);
        checkOutput("ovf_full8",  32'(full),   32'h1);
        checkOutput("ovf_count8", 32'(count),  32'h8);
        checkOutput("ovf_none8",  32'(ovSeen), 32'h0);
        applyStimulus(1'b0, 8'h08, 1'b1);
        checkOutput("ovf_pulse9", 32'(ovSeen), 32'h1);
        checkOutput("ovf_count9", 32'(count),  32'h8);
        for (int i = 0; i < 8; i++) popExpect("ovf_drain", 32'(i));
        checkOutput("ovf_drained", 32'(empty), 32'h1);

        // Full FIFO with a pop landing on the commit edge.
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'(8'h10 + i), 1'b1);
        checkOutput("simul_full_before", 32'(full), 32'h1);
        fork
            applyStimulus(1'b0, 8'h18, 1'b1);
            begin
                @(negedge clk);
                @(posedge clk);
                repeat (169) @(posedge clk);
                @(negedge clk);
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        join
        checkOutput("simul_count", 32'(count),  32'h8);
        checkOutput("simul_ovf",   32'(ovSeen), 32'h1);
        for (int i = 1; i <= 8; i++) popExpect("simul_drain", 32'(8'h10 + i));
        checkOutput("simul_empty", 32'(empty), 32'h1);

        // Framing error followed by a 40-bit break.
        applyStimulus(1'b0, 8'h55, 1'b0);
        repeat (40 * CPB) @(negedge clk);
        rx_i = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        checkOutput("ferr_pulses",    32'(ferrSeen),  32'h1);
        checkOutput("ferr_addressed", 32'(addressed), 32'h1);
        checkOutput("ferr_empty",     32'(empty),     32'h1);
        applyStimulus(1'b0, 8'h3C, 1'b1);
        popExpect("ferr_recover", 32'h3C);

        // Short glitch is rejected as a false start.
        @(negedge clk);
        rx_i = 1'b0;
        repeat (3) @(negedge clk);
        rx_i = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("glitch_empty", 32'(empty),    32'h1);
        checkOutput("glitch_ferr",  32'(ferrSeen), 32'h1);
        checkOutput("glitch_ovf",   32'(ovSeen),   32'h1);
        applyStimulus(1'b0, 8'h77, 1'b1);
        popExpect("glitch_recover", 32'h77);

        // Reset in the middle of a data frame.
        applyStimulus(1'b0, 8'h5A, 1'b1);
        checkOutput("mid_rst_pre_count", 32'(count), 32'h1);
        @(negedge clk);
        rx_i = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_addressed", 32'(addressed), 32'h0);
        checkOutput("mid_rst_count",     32'(count),     32'h0);
        checkOutput("mid_rst_empty",     32'(empty),     32'h1);
        checkOutput("mid_rst_rd_data",   32'(rd_data),   32'h0);
        rx_i = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        applyStimulus(1'b1, 8'h06, 1'b1);
        applyStimulus(1'b0, 8'h42, 1'b1);
        checkOutput("post_rst_addressed", 32'(addressed), 32'h1);
        checkOutput("post_rst_count",     32'(count),     32'h1);
        popExpect("post_rst_data", 32'h42);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/uart9_addr_rx.md
# uart9_addr_rx

Parametrised 9-bit multiprocessor UART receiver. It deserialises frames of DATA_W data bits plus an address/data flag bit, and matches address frames against a node address or a broadcast address. Data frames that follow a matching address are buffered in a first-word-fall-through FIFO. It is the next generation of our uart_slave, which took pre-parallelised 9-bit words, and it sits between the board RX pin and the local memory/processor interface.

## Interface
Parameters:
- DATA_W, 8: data bits per frame, excluding the flag bit.
- CLKS_PER_BIT, 16: clk cycles per bit. Must be even and ≥ 4.
- FIFO_DEPTH, 8: receive FIFO entries. Must be a power of two and ≥ 2.
- BCAST_ADDR, all-ones (DATA_W bits): broadcast address that every node accepts.

Ports:
- clk, in, 1: the single clock. All logic is on its rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- rx_i, in, 1: serial line. Idle high. Asynchronous to clk.
- my_addr, in, DATA_W: this node's address. Sampled when an address frame completes.
- rd_en, in, 1: pops the FIFO head. Ignored when empty.
- rd_data, out, DATA_W: FIFO head. Valid whenever empty=0.
- empty, out, 1: FIFO holds no entries.
- full, out, 1: FIFO holds FIFO_DEPTH entries.
- count, out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- addressed, out, 1: the node is currently selected.
- frame_err, out, 1: one-cycle pulse when a stop bit is sampled low.
- overflow, out, 1: one-cycle pulse when a valid data frame is dropped because the FIFO is full.

## Operation
- rx_i passes through a 2-flop synchroniser, giving rx_s. All decisions use rx_s.
- Frame format: start bit (0), then DATA_W data bits LSB first, then the flag bit, then the stop bit (1). Flag=1 marks an address frame; flag=0 marks a data frame.
- State machine:
  - IDLE: on rx_s=0, go to START and clear the bit counter.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. If rx_s=1 it is a false start: return to IDLE. If rx_s=0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles and shift in DATA_W bits. Then go to FLAG.
  - FLAG: sample the flag bit after CLKS_PER_BIT cycles. Then go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - If rx_s=1 the frame is valid: commit it (below) and go to IDLE.
    - If rx_s=0: pulse frame_err, discard the frame, leave addressed unchanged, and go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then go to IDLE. This covers breaks.
- Committing a valid address frame:
  - addressed ← (data == my_addr) || (data == BCAST_ADDR).
  - The address byte is never written to the FIFO.
- Committing a valid data frame:
  - If addressed=0, discard silently.
  - If addressed=1 and the FIFO has room, write the data.
  - If addressed=1 and the FIFO is full, pulse overflow and drop the data. Existing entries are kept.
- FIFO behaviour:
  - Circular buffer. Read and write pointers wrap modulo FIFO_DEPTH.
  - full = (count == FIFO_DEPTH); empty = (count == 0).
  - A simultaneous pop and push always succeed, including when full. count is then unchanged and overflow does not fire.
  - A pop while empty is a no-op.
- Reset (asynchronous, any state): FSM returns to IDLE; pointers and count clear. The synchroniser resets to 1.
- Reset values of outputs: empty=1, full=0, count=0, addressed=0, frame_err=0, overflow=0, rd_data=0.
- A frame in progress when reset asserts is lost.

## Timing
- Let t0 be the first clk edge at which the synchroniser input flop captures rx_i=0.
- rx_s falls at t0+1.
- A bit with index i (start=0, data=1..DATA_W, flag=DATA_W+1, stop=DATA_W+2) is sampled at t0+1+CLKS_PER_BIT/2+i·CLKS_PER_BIT.
- The commit register updates one cycle after the stop sample:
  - FIFO write and count increment.
  - Update of addressed.
  - frame_err or overflow pulse.
- empty falls in that same cycle. rd_data is valid from that cycle.
- With defaults, the stop bit is sampled at t0+169 and the commit lands at t0+170.
- Pop: rd_en high at edge k → count decrements and rd_data shows the next entry after edge k.
- Back-to-back frames are supported: a start bit beginning immediately after a one-bit stop is detected.
- Supported baud mismatch: ±2 % between transmitter and receiver.

## Test plan
- Address match then data, with my_addr=8'h06, defaults:
  - Stimulus: frame {flag=1, 8'h06}, then {flag=0, 8'hF0}.
  - Response: addressed=1 at t0+170; then rd_data=8'hF0, empty=0, count=1.
- Address mismatch, with my_addr=8'h06:
  - Stimulus: frame {flag=1, 8'h05}, then {flag=0, 8'h0E}.
  - Response: addressed=0, empty stays 1, no pulses.
- Broadcast:
  - Stimulus: {flag=1, 8'hFF}, then {flag=0, 8'hA5}.
  - Response: addressed=1, rd_data=8'hA5.
- Overflow:
  - Stimulus: while addressed, send 9 data frames 8'h00..8'h08 with no reads.
  - Response: full=1 after the 8th frame; overflow pulses once on the 9th; popping yields 8'h00..8'h07 in order.
  - Follow-up: with full, pop in the same cycle a 9th frame commits. Response: count stays 8, no overflow pulse.
- Framing error:
  - Stimulus: stop bit driven 0, then rx held low 40 bit times, then released.
  - Response: frame_err pulses once, addressed is unchanged, nothing is written, no new frame starts before rx returns high.
- Reset and false start:
  - Stimulus: a 3-cycle low glitch on rx → Response: FSM returns to IDLE, no output activity.
  - Stimulus: rst_n pulsed low mid-data-frame → Response: all outputs at their reset values immediately; the next clean frame is received correctly.
